mynios2_cpu_mul_sequencer: RTL and testbench

- Multi-cycle controller that builds a full 32x32->64 product (mulxss/mulxsu/mulxuu plus low-word mul) by sequencing four 16x16 unsigned partial products through one shared, externally instantiated registered 16x16 multiplier.
- Accumulates the partial products, then applies the two's-complement correction for signed operands.
- Sits between the Nios II A-stage and a single dedicated multiplier block, freeing the second DSP slice used by the split low-word multiply cell.

---
 rtl/mynios2_cpu_mul_sequencer.sv | 175 +++++++++++++++++
 tb/tb_mynios2_cpu_mul_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mynios2_cpu_mul_sequencer.sv
// rtl/mynios2_cpu_mul_sequencer.sv - 32x32->64 multiply built from four 16x16 partial products
// issued to one shared external registered multiplier, with signed correction applied at the end.
module mynios2_cpu_mul_sequencer #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        src1_signed,
  input  logic        src2_signed,
  input  logic        abort,
  output logic        mul_en,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [31:0] mul_p,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result_hi,
  output logic [31:0] result_lo,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL0, S_MUL1, S_MUL2, S_MUL3, S_WAIT, S_FIX, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, b_q;
  logic        a_sgn_q, b_sgn_q;
  logic [63:0] acc_q, acc_d;
  logic [31:0] res_hi_q, res_lo_q;
  logic        tag_v_q   [MUL_LATENCY];
  logic [1:0]  tag_idx_q [MUL_LATENCY];

  logic        accept;
  logic        kill;
  logic [1:0]  issue_idx;
  logic        tag_out_v;
  logic [1:0]  tag_out_idx;
  logic        tag_done;
  logic [63:0] pp_ext;
  logic [63:0] pp_shifted;
  logic [31:0] hi_fix;

  assign tag_out_v   = tag_v_q[MUL_LATENCY-1];
  assign tag_out_idx = tag_idx_q[MUL_LATENCY-1];
  assign tag_done    = tag_out_v && (tag_out_idx == 2'd3);
  assign kill        = abort && (state_q != S_IDLE);

  assign start_ready  = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign result_hi    = res_hi_q;
  assign result_lo    = res_lo_q;

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    mul_en    = 1'b0;
    mul_a     = 16'd0;
    mul_b     = 16'd0;
    issue_idx = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          accept  = 1'b1;
          state_d = S_MUL0;
        end
      end
      S_MUL0: begin
        mul_en    = 1'b1;
        mul_a     = a_q[15:0];
        mul_b     = b_q[15:0];
        issue_idx = 2'd0;
        state_d   = S_MUL1;
      end
      S_MUL1: begin
        mul_en    = 1'b1;
        mul_a     = a_q[31:16];
        mul_b     = b_q[15:0];
        issue_idx = 2'd1;
        state_d   = S_MUL2;
      end
      S_MUL2: begin
        mul_en    = 1'b1;
        mul_a     = a_q[15:0];
        mul_b     = b_q[31:16];
        issue_idx = 2'd2;
        state_d   = S_MUL3;
      end
      S_MUL3: begin
        mul_en    = 1'b1;
        mul_a     = a_q[31:16];
        mul_b     = b_q[31:16];
        issue_idx = 2'd3;
        state_d   = tag_done ? S_FIX : S_WAIT;
      end
      S_WAIT:  if (tag_done) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  if (result_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort suppresses the issue in the same cycle so no product is launched for a dead op.
    if (kill) begin
      state_d = S_IDLE;
      mul_en  = 1'b0;
      mul_a   = 16'd0;
      mul_b   = 16'd0;
    end
  end

  always_comb begin
    pp_ext = {32'd0, mul_p};
    case (tag_out_idx)
      2'd0:    pp_shifted = pp_ext;
      2'd3:    pp_shifted = pp_ext << 32;
      default: pp_shifted = pp_ext << 16;
    endcase
    acc_d = acc_q;
    if (accept)         acc_d = 64'd0;
    else if (tag_out_v) acc_d = acc_q + pp_shifted;
  end

  // Unsigned product minus 2^32 * (the other operand) for each negative signed operand.
  assign hi_fix = acc_q[63:32]
                - ((a_sgn_q && a_q[31]) ? b_q : 32'd0)
                - ((b_sgn_q && b_q[31]) ? a_q : 32'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      a_sgn_q  <= 1'b0;
      b_sgn_q  <= 1'b0;
      acc_q    <= 64'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      for (int i = 0; i < MUL_LATENCY; i++) begin
        tag_v_q[i]   <= 1'b0;
        tag_idx_q[i] <= 2'd0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      if (accept) begin
        a_q     <= src1;
        b_q     <= src2;
        a_sgn_q <= src1_signed;
        b_sgn_q <= src2_signed;
      end
      if (state_q == S_FIX && !abort) begin
        res_hi_q <= hi_fix;
        res_lo_q <= acc_q[31:0];
      end
      if (kill) begin
        for (int i = 0; i < MUL_LATENCY; i++) begin
          tag_v_q[i]   <= 1'b0;
          tag_idx_q[i] <= 2'd0;
        end
      end else begin
        tag_v_q[0]   <= mul_en;
        tag_idx_q[0] <= issue_idx;
        for (int i = 1; i < MUL_LATENCY; i++) begin
          tag_v_q[i]   <= tag_v_q[i-1];
          tag_idx_q[i] <= tag_idx_q[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_mynios2_cpu_mul_sequencer.sv
// tb/tb_mynios2_cpu_mul_sequencer.sv - bench for the multiply sequencer at latencies 1 and 3.
module tb_mynios2_cpu_mul_sequencer;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        abort;
  logic [31:0] src1, src2;
  logic        src1_signed, src2_signed;
  logic [1:0]  start_valid, start_ready, result_ready, result_valid, busy, mul_en;
  logic [15:0] mul_a [2];
  logic [15:0] mul_b [2];
  logic [31:0] mul_p [2];
  logic [31:0] result_hi [2];
  logic [31:0] result_lo [2];

  int checks = 0;
  int errors = 0;

  mynios2_cpu_mul_sequencer #(.MUL_LATENCY(LAT0)) u_l1 (
    .clk(clk), .reset_n(reset_n),
    .start_valid(start_valid[0]), .start_ready(start_ready[0]),
    .src1(src1), .src2(src2), .src1_signed(src1_signed), .src2_signed(src2_signed),
    .abort(abort), .mul_en(mul_en[0]), .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_p(mul_p[0]),
    .result_valid(result_valid[0]), .result_ready(result_ready[0]),
    .result_hi(result_hi[0]), .result_lo(result_lo[0]), .busy(busy[0])
  );

  mynios2_cpu_mul_sequencer #(.MUL_LATENCY(LAT1)) u_l3 (
    .clk(clk), .reset_n(reset_n),
    .start_valid(start_valid[1]), .start_ready(start_ready[1]),
    .src1(src1), .src2(src2), .src1_signed(src1_signed), .src2_signed(src2_signed),
    .abort(abort), .mul_en(mul_en[1]), .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_p(mul_p[1]),
    .result_valid(result_valid[1]), .result_ready(result_ready[1]),
    .result_hi(result_hi[1]), .result_lo(result_lo[1]), .busy(busy[1])
  );

  // Registered 16x16 multipliers; idle cycles return junk so unqualified accumulation shows up.
  logic [31:0] p0_q;
  logic [31:0] p1_q [3];
  always_ff @(posedge clk) begin
    p0_q    <= mul_en[0] ? ({16'd0, mul_a[0]} * {16'd0, mul_b[0]}) : 32'hDEADBEEF;
    p1_q[0] <= mul_en[1] ? ({16'd0, mul_a[1]} * {16'd0, mul_b[1]}) : 32'hDEADBEEF;
    p1_q[1] <= p1_q[0];
    p1_q[2] <= p1_q[1];
  end
  assign mul_p[0] = p0_q;
  assign mul_p[1] = p1_q[2];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sa;
    logic        sb;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic sa, input logic sb, input int hold,
                        output logic [63:0] res);
    int  guard;
    int  lat;
    int  en_cnt;
    int  en_first;
    int  en_last;
    bit  got;
    guard = 0;
    while (!start_ready[k] && guard < 30) begin
      tick();
      guard++;
    end
    check($sformatf("start_ready_before_op%0d", k), start_ready[k], 1);
    src1 = a; src2 = b; src1_signed = sa; src2_signed = sb;
    start_valid[k] = 1'b1;
    tick();
    start_valid[k] = 1'b0;
    src1 = ~a; src2 = ~b; src1_signed = ~sa; src2_signed = ~sb;
    lat = 0; en_cnt = 0; en_first = -1; en_last = -1; got = 0; res = '0;
    while (!got && lat < 40) begin
      if (result_valid[k]) got = 1;
      else begin
        if (mul_en[k]) begin
          en_cnt++;
          if (en_first < 0) en_first = lat;
          en_last = lat;
        end
        tick();
        lat++;
      end
    end
    check($sformatf("latency%0d", k), lat, 5 + ((k == 0) ? LAT0 : LAT1));
    check($sformatf("mul_en_count%0d", k), en_cnt, 4);
    check($sformatf("mul_en_span%0d", k), en_last - en_first, 3);
    if (got) res = {result_hi[k], result_lo[k]};
    for (int i = 0; i < hold; i++) begin
      tick();
      check($sformatf("backpressure_hold%0d_%0d", k, i),
            {result_valid[k], start_ready[k], result_hi[k], result_lo[k]}, {2'b10, res});
    end
    result_ready[k] = 1'b1;
    tick();
    result_ready[k] = 1'b0;
    check($sformatf("idle_after_done%0d", k),
          {start_ready[k], result_valid[k], busy[k]}, 3'b100);
    check($sformatf("result_held%0d", k), {result_hi[k], result_lo[k]}, res);
  endtask

  task automatic abort_in_mul2(input int k);
    src1 = 32'h12345678; src2 = 32'h9ABCDEF0; src1_signed = 1'b0; src2_signed = 1'b0;
    start_valid[k] = 1'b1;
    tick();
    start_valid[k] = 1'b0;
    tick();
    tick();
    check($sformatf("mul2_operands%0d", k), {mul_en[k], mul_a[k], mul_b[k]}, {1'b1, 16'h5678, 16'h9ABC});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check($sformatf("abort_to_idle%0d", k),
          {start_ready[k], busy[k], result_valid[k], mul_en[k]}, 4'b1000);
  endtask

  logic [63:0] res;

  initial begin
    reset_n = 1'b0;
    abort = 1'b0;
    src1 = '0; src2 = '0; src1_signed = 1'b0; src2_signed = 1'b0;
    start_valid = '0;
    result_ready = '0;

    vecs[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE_00000001};
    vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h00000000_00000001};
    vecs[2]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h40000000_00000000};
    vecs[3]  = '{32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFE};
    vecs[4]  = '{32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFFE};
    vecs[5]  = '{32'h00000003, 32'h00000005, 1'b0, 1'b0, 64'h00000000_0000000F};
    vecs[6]  = '{32'h00010000, 32'h00010000, 1'b0, 1'b0, 64'h00000001_00000000};
    vecs[7]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 64'h3FFFFFFF_00000001};
    vecs[8]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 64'hFFFFFFFF_80000000};
    vecs[9]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 64'hFFFFFFFF_80000000};
    vecs[10] = '{32'h00010001, 32'h00010001, 1'b0, 1'b0, 64'h00000001_00020001};

    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset_ctrl%0d", k),
            {start_ready[k], busy[k], mul_en[k], result_valid[k]}, 4'b1000);
      check($sformatf("reset_data%0d", k),
            {mul_a[k], mul_b[k], result_hi[k], result_lo[k]}, 96'd0);
    end
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      run_op(0, vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb, 0, res);
      check($sformatf("vec%0d", i), res, vecs[i].exp);
    end

    run_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 3, res);
    check("backpressure_result", res, 64'hFFFFFFFE_00000001);
    run_op(0, 32'h00010000, 32'h00010000, 1'b0, 1'b0, 0, res);
    check("back_to_back_result", res, 64'h00000001_00000000);

    abort_in_mul2(0);
    run_op(0, 32'd3, 32'd5, 1'b0, 1'b0, 0, res);
    check("after_abort_l1", res, 64'h0000000F);

    src1 = 32'hFFFFFFFF; src2 = 32'h00000002; src1_signed = 1'b1; src2_signed = 1'b0;
    start_valid[0] = 1'b1;
    tick();
    start_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("in_wait", {busy[0], mul_en[0], result_valid[0]}, 3'b100);
    #1 reset_n = 1'b0;
    #1;
    check("mid_reset_ctrl", {start_ready[0], busy[0], mul_en[0], result_valid[0]}, 4'b1000);
    check("mid_reset_data", {mul_a[0], mul_b[0], result_hi[0], result_lo[0]}, 96'd0);
    reset_n = 1'b1;
    tick();
    run_op(0, 32'd3, 32'd5, 1'b0, 1'b0, 0, res);
    check("after_reset_l1", res, 64'h0000000F);

    run_op(1, 32'h00010000, 32'h00010000, 1'b0, 1'b0, 0, res);
    check("l3_unsigned", res, 64'h00000001_00000000);
    run_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 0, res);
    check("l3_signed", res, 64'h00000000_00000001);
    abort_in_mul2(1);
    run_op(1, 32'd3, 32'd5, 1'b0, 1'b0, 0, res);
    check("after_abort_l3", res, 64'h0000000F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
